// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding selects, Tuse sentinel and stage record for the hazard tracker
package hazard_pkg;
  localparam logic [1:0] FWD_RF = 2'd0, FWD_E = 2'd1, FWD_M = 2'd2;
  localparam logic [1:0] FWD_IDEX = 2'd0, FWD_FROM_M = 2'd1, FWD_FROM_W = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  typedef struct packed {
    logic [4:0] a1;
    logic [4:0] a2;
    logic [4:0] a3;
    logic       we;
    logic [1:0] tnew;
  } stage_t;
  function automatic logic hit(input logic [4:0] a, input stage_t s);
    return (a != 5'd0) && s.we && (s.a3 == a);
  endfunction
  function automatic logic late(input logic [4:0] a, input stage_t s, input logic [1:0] tuse);
    return hit(a, s) && (s.tnew > tuse);
  endfunction
  // the youngest matching stage decides; a not-yet-ready young match blocks older ones
  function automatic logic [1:0] pick(input logic [4:0] a, input stage_t y, input stage_t o,
                                      input logic [1:0] y_sel, input logic [1:0] o_sel);
    return hit(a, y) ? ((y.tnew == 2'd0) ? y_sel : 2'd0)
         : (hit(a, o) && o.tnew == 2'd0) ? o_sel : 2'd0;
  endfunction
endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one pipeline stage record with synchronous clear and bubble insertion
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   bubble,
  input  stage_t din,
  output stage_t rec_q
);
  stage_t rec_d;
  always_comb rec_d = (rst || bubble) ? '0 : din;
  always_ff @(posedge clk) rec_q <= rec_d;
endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker: Tuse/Tnew stall and forwarding-select generation for the five-stage pipeline
module hazard_tracker
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs_addr,
  input  logic [4:0] d_rt_addr,
  input  logic [4:0] d_a3,
  input  logic       d_we,
  input  logic       d_rs,
  input  logic       d_rt,
  input  logic       e_rs,
  input  logic       e_rt,
  input  logic       d_sw,
  input  logic       e_not,
  input  logic       m_not,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       fwd_m_rt
);
  stage_t e_in, m_in, w_in, e_q, m_q, w_q;
  logic [1:0] tuse_rs, tuse_rt;
  logic unused;
  always_comb begin
    tuse_rs = d_rs ? 2'd0 : e_rs ? 2'd1 : TUSE_NONE;
    tuse_rt = d_rt ? 2'd0 : e_rt ? 2'd1 : d_sw ? 2'd2 : TUSE_NONE;
    e_in = '{a1: d_rs_addr, a2: d_rt_addr, a3: d_a3, we: d_we,
             tnew: m_not ? 2'd2 : e_not ? 2'd1 : 2'd0};
    m_in = '{a1: 5'd0, a2: e_q.a2, a3: e_q.a3, we: e_q.we,
             tnew: (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1};
    w_in = '{a1: 5'd0, a2: 5'd0, a3: m_q.a3, we: m_q.we, tnew: 2'd0};
    stall = late(d_rs_addr, e_q, tuse_rs) || late(d_rs_addr, m_q, tuse_rs) ||
            late(d_rt_addr, e_q, tuse_rt) || late(d_rt_addr, m_q, tuse_rt);
    fwd_d_rs = pick(d_rs_addr, e_q, m_q, FWD_E, FWD_M);
    fwd_d_rt = pick(d_rt_addr, e_q, m_q, FWD_E, FWD_M);
    fwd_e_rs = pick(e_q.a1, m_q, w_q, FWD_FROM_M, FWD_FROM_W);
    fwd_e_rt = pick(e_q.a2, m_q, w_q, FWD_FROM_M, FWD_FROM_W);
    fwd_m_rt = hit(m_q.a2, w_q);
  end
  assign unused = ^{m_q.a1, w_q.a1, w_q.a2};
  hazard_stage_reg u_e (.clk(clk), .rst(reset), .bubble(stall), .din(e_in), .rec_q(e_q));
  hazard_stage_reg u_m (.clk(clk), .rst(reset), .bubble(1'b0), .din(m_in), .rec_q(m_q));
  hazard_stage_reg u_w (.clk(clk), .rst(reset), .bubble(1'b0), .din(w_in), .rec_q(w_q));
endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Hazard tracker for the five-stage MIPS pipeline. It sits beside the decode stage and consumes the decoder's per-instruction hazard flags. It keeps its own copy of the destination and readiness state for the E, M and W stages, and uses it to drive the pipeline stall and every forwarding-mux select. It is the only owner of Tuse/Tnew hazard logic in the core.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all stage records.
- d_rs_addr  in  5  rs field of the instruction in D.
- d_rt_addr  in  5  rt field of the instruction in D.
- d_a3  in  5  resolved write register of the instruction in D (rd, rt or 31).
- d_we  in  1  instruction in D writes the register file.
- d_rs, d_rt  in  1  rs/rt read in D (Tuse 0).
- e_rs, e_rt  in  1  rs/rt read in E (Tuse 1).
- d_sw  in  1  rt read in M as store data (Tuse 2).
- e_not  in  1  result not available while in E.
- m_not  in  1  result not available while in M (load).
- stall  out  1  freeze PC and IF/ID, insert a bubble into ID/EX.
- fwd_d_rs, fwd_d_rt  out  2  D-stage compare/jr operand: 0 RF, 1 from E, 2 from M.
- fwd_e_rs, fwd_e_rt  out  2  ALU operand: 0 ID/EX value, 1 from M, 2 from W.
- fwd_m_rt  out  1  store data: 0 EX/MEM value, 1 from W.

## Operation
- **Stage records.**
  - E holds {a1, a2, a3, we, tnew[1:0]}.
  - M holds {a2, a3, we, tnew}.
  - W holds {a3, we}; its Tnew is always 0.
- **Tnew on entry to E.** m_not gives 2, otherwise e_not gives 1, otherwise 0.
- **Tnew on entry to M.** E.tnew − 1, saturating at 0.
- **Tuse for rs.** d_rs gives 0, otherwise e_rs gives 1, otherwise 3.
- **Tuse for rt.** d_rt gives 0, otherwise e_rt gives 1, otherwise d_sw gives 2, otherwise 3.
- **Match.** A register matches a stage when the address is non-zero, the stage has we = 1, and stage.a3 equals the address. Register $0 never matches.
- **Stall.** stall = 1 when any match exists in E or M with stage.tnew > Tuse, checked for rs and for rt.
  - W never causes a stall.
  - stall is combinational from the D inputs and the registered records.
- **Forward priority.** The youngest stage wins, and it may forward only when its tnew = 0.
  - fwd_d: E, then M, then RF.
  - fwd_e: uses E.a1/E.a2; checks M, then W.
  - fwd_m_rt: uses M.a2; checks W.
  - A W-to-D hazard is resolved by register-file write-through, not by this block.
- **Stall cycle.** The E record loads a bubble (all fields 0). M ← E and W ← M advance as normal.
- **Normal cycle.** E ← D fields, M ← E, W ← M.

## Timing
- Reset is synchronous. On the first edge with reset high, all records become 0. stall and every fwd_* output are 0 during the following cycle, and stay 0 until non-hazard D inputs produce otherwise.
- Outputs are valid in the same cycle as their D inputs. There is no added latency.
- Maximum stall for a single dependency is 2 cycles. Example: lw followed immediately by beq on the same register; Tnew is 2 then 1, against Tuse 0.
- A reset that arrives during a stall wins. The records clear and stall drops on the next cycle.
- Simultaneous matches in E and M: E has priority for forwarding. Stall is the OR of both stages' stall conditions.

## Structure
- Shared package `hazard_pkg` holds:
  - constants FWD_RF/FWD_E/FWD_M and FWD_IDEX/FWD_FROM_M/FWD_FROM_W;
  - constant TUSE_NONE = 3;
  - the stage-record typedef.
- One natural sub-module, `hazard_stage_reg`: a single record register with a bubble input. It is instantiated three times with the unused fields tied to 0.

## Test plan
- **Load–use.** lw $1 in E (m_not), add $2,$1,$3 in D → stall = 1 for one cycle. Next cycle: E is a bubble, M.tnew = 1, stall = 0. The cycle after that: add is in E with lw in W → fwd_e_rs = 2.
- **Branch after ALU.** add $4 (e_not) in E, beq $4,$5 in D → stall = 1 for one cycle. Then the add reaches M with tnew 0 → fwd_d_rs = 2, stall = 0.
- **Store data.** lw $6 directly followed by sw $6 → stall = 0 throughout. When sw is in M and lw is in W → fwd_m_rt = 1.
- **Register $0.** ori $0 in E, beq $0,$0 in D → stall = 0 and fwd_d_rs = fwd_d_rt = 0.
- **jal.** jal in E with a3 = 31 and tnew 0, jr $31 in D → stall = 0 and fwd_d_rs = 1.
- **Reset mid-stall.** Assert reset while stall = 1 during a load–use hazard → the next cycle has stall = 0, all fwd_* = 0, and every record is 0.
